apb_modport: RTL and testbench
==============================

# apb_modport

APB subsystem that the APB VIP drives through its DRV/MON interface: one APB master state machine bridging a simple request port onto an internal APB bus with two memory-backed slaves. The MSB of the address selects the slave. Read data and slave error are returned to the request side.

## Interface
- `ADDR_WIDTH`, default 8: slave-local address width; request addresses are `ADDR_WIDTH+1` bits.
- `DATA_WIDTH`, default 8: data width.
- `PCLK` input, 1 bit: single clock; all logic uses posedge.
- `PRESETn` input, 1 bit: reset is asynchronous and active-high. `PRESETn`=1 resets the block; the name is kept for codebase consistency.
- `transfer` input, 1 bit: request valid, sampled at posedge.
- `READ_WRITE` input, 1 bit: 1 = write, 0 = read.
- `apb_write_paddr` input, ADDR_WIDTH+1 bits: write address. MSB selects slave (0 = slave0, 1 = slave1); lower bits are the word index.
- `apb_read_paddr` input, ADDR_WIDTH+1 bits: read address, same encoding.
- `apb_write_data` input, DATA_WIDTH bits: write data.
- `apb_read_data_out` output, DATA_WIDTH bits: last completed read data, registered.
- `PSLVERR` output, 1 bit: error status of the last completed transfer, registered.

## Operation
- Internal APB bus: PADDR, PWDATA, PWRITE, PSEL1/PSEL2, PENABLE, PREADY, PRDATA, per-slave PSLVERR.
- Each slave has 2^ADDR_WIDTH words of DATA_WIDTH bits, plus one written-valid bit per word.
- Master FSM states:
  - IDLE: leave when `transfer`=1, go to SETUP.
  - SETUP: PSEL asserted, PENABLE=0. Always go to ACCESS on the next cycle.
  - ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0. On PREADY=1, go to SETUP if `transfer`=1, else IDLE.
- Request capture: at the posedge entering SETUP, latch READ_WRITE, the address (`apb_write_paddr` if write, else `apb_read_paddr`) and `apb_write_data`. These are held stable through ACCESS.
- PSEL1 is asserted when the latched address MSB=0; PSEL2 when MSB=1. Never both.
- Write completion (ACCESS with PREADY=1): store the word and set its valid bit. PSLVERR=0.
- Read completion: `apb_read_data_out` takes the PRDATA of the selected slave.
  - PSLVERR=1 if the word's valid bit is 0; data returned is 0.
  - Otherwise PSLVERR=0.
- `apb_read_data_out` holds its value across writes and idle cycles. `PSLVERR` holds until the next completion.
- Reset (async) sets:
  - FSM to IDLE, PSEL/PENABLE to 0.
  - `apb_read_data_out`=0, `PSLVERR`=0.
  - All valid bits and memory words to 0.
- Reset mid-transfer aborts the transfer with no memory update.

## Timing
- `transfer` sampled 1 at edge k: SETUP during k..k+1, ACCESS from k+1. Without wait states, completion is at edge k+2.
- Read data and PSLVERR are visible after edge k+2, a 2-cycle latency.
- Back-to-back: `transfer` held high gives one transfer every 2 cycles (SETUP/ACCESS alternating).
- Write followed immediately by a read of the same address returns the new data.
- Inputs change only via the drive clocking block (output skew #1), so no same-edge races.

## Configuration
- `APB_WAIT_STATE_EN`:
  - Defined: each slave drives PREADY=0 in the first ACCESS cycle and 1 in the second. Every transfer takes 3 cycles, and completion for a request sampled at edge k is at edge k+3.
  - Undefined: PREADY is tied to 1 and completion is at edge k+2.

## Test plan
- Reset: assert `PRESETn`=1 mid-run -> `apb_read_data_out`=0, `PSLVERR`=0, no transfer in progress; a subsequent read of 9'h005 gives PSLVERR=1, data 0.
- Write 9'h012 = 8'hA5, then read 9'h012 -> `apb_read_data_out`=8'hA5, PSLVERR=0, 2 cycles after `transfer` is sampled (3 with `APB_WAIT_STATE_EN`).
- Slave select: write 9'h012=8'h11 and 9'h112=8'h22, read both -> 8'h11 and 8'h22, no aliasing.
- Back-to-back: `transfer` held 1 for four writes to 9'h000..9'h003 (8'h10..8'h13), then reads -> each value correct, one completion every 2 cycles.
- Unwritten read: read 9'h1FF after reset -> PSLVERR=1, `apb_read_data_out`=0; the following valid read clears PSLVERR to 0.

Source files
------------

// File: rtl/apb_modport.sv
// APB master FSM bridging a request port onto an internal bus with two memory-backed slaves.
// Define APB_WAIT_STATE_EN to make each slave insert one wait state per transfer.
module apb_modport #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH:0]   apb_write_paddr,
  input  logic [ADDR_WIDTH:0]   apb_read_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  output logic [DATA_WIDTH-1:0] apb_read_data_out,
  output logic                  PSLVERR
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]            r_state;
  logic                  r_pwrite;
  logic [ADDR_WIDTH:0]   r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;

  logic [DATA_WIDTH-1:0] r_mem1 [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem2 [DEPTH];
  logic [DEPTH-1:0]      r_valid1;
  logic [DEPTH-1:0]      r_valid2;

  logic                  w_psel1;
  logic                  w_psel2;
  logic                  w_penable;
  logic                  w_pready;
  logic                  w_capture;
  logic                  w_complete;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [DATA_WIDTH-1:0] w_prdata1;
  logic [DATA_WIDTH-1:0] w_prdata2;
  logic                  w_pslverr1;
  logic                  w_pslverr2;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_pslverr;

  assign w_index   = r_paddr[ADDR_WIDTH-1:0];
  assign w_psel1   = (r_state != IDLE) && !r_paddr[ADDR_WIDTH];
  assign w_psel2   = (r_state != IDLE) &&  r_paddr[ADDR_WIDTH];
  assign w_penable = (r_state == ACCESS);

`ifdef APB_WAIT_STATE_EN
  // Remembers that the first ACCESS cycle has passed, so PREADY rises in the second.
  logic r_waited;

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) r_waited <= 1'b0;
    else         r_waited <= w_penable && !r_waited;
  end

  assign w_pready = r_waited;
`else
  assign w_pready = 1'b1;
`endif

  assign w_complete = (w_psel1 || w_psel2) && w_penable && w_pready;
  assign w_capture  = transfer && ((r_state == IDLE) || w_complete);

  // Unwritten words read back as zero and flag a slave error.
  assign w_prdata1  = r_valid1[w_index] ? r_mem1[w_index] : '0;
  assign w_prdata2  = r_valid2[w_index] ? r_mem2[w_index] : '0;
  assign w_pslverr1 = !r_pwrite && !r_valid1[w_index];
  assign w_pslverr2 = !r_pwrite && !r_valid2[w_index];
  assign w_prdata   = w_psel2 ? w_prdata2  : w_prdata1;
  assign w_pslverr  = w_psel2 ? w_pslverr2 : w_pslverr1;

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (transfer) r_state <= SETUP;
        SETUP:   r_state <= ACCESS;
        ACCESS:  if (w_pready) r_state <= transfer ? SETUP : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_capture) begin
      r_pwrite <= READ_WRITE;
      r_paddr  <= READ_WRITE ? apb_write_paddr : apb_read_paddr;
      r_pwdata <= apb_write_data;
    end
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem1[i] <= '0;
        r_mem2[i] <= '0;
      end
      r_valid1 <= '0;
      r_valid2 <= '0;
    end else if (w_complete && r_pwrite) begin
      if (w_psel1) begin
        r_mem1[w_index]   <= r_pwdata;
        r_valid1[w_index] <= 1'b1;
      end else begin
        r_mem2[w_index]   <= r_pwdata;
        r_valid2[w_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      apb_read_data_out <= '0;
      PSLVERR           <= 1'b0;
    end else if (w_complete) begin
      if (r_pwrite) begin
        PSLVERR <= 1'b0;
      end else begin
        apb_read_data_out <= w_prdata;
        PSLVERR           <= w_pslverr;
      end
    end
  end

endmodule

// File: tb/tb_apb_modport.sv
// Directed bench for apb_modport: vector table of single transfers plus back-to-back and reset sequences.
module tb_apb_modport;

`ifdef APB_WAIT_STATE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       transfer;
  logic       READ_WRITE;
  logic [8:0] apb_write_paddr;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_write_data;
  logic [7:0] apb_read_data_out;
  logic       PSLVERR;

  int nCompared   = 0;
  int nMismatched = 0;
  logic [7:0] prevData;
  logic       prevErr;

  typedef struct {
    logic       rw;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] expData;
    logic       expErr;
  } vec_t;

  vec_t vecs [13];

  apb_modport #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_data_out (apb_read_data_out),
    .PSLVERR           (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // The unused address port gets the complement so a wrong address mux shows up.
  task automatic applyStimulus(input logic rw, input logic [8:0] addr, input logic [7:0] wdata);
    transfer        = 1'b1;
    READ_WRITE      = rw;
    apb_write_paddr = rw ? addr : ~addr;
    apb_read_paddr  = rw ? ~addr : addr;
    apb_write_data  = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One isolated transfer: outputs must hold until edge k+LAT, then show the result.
  task automatic runXfer(input string name, input logic rw, input logic [8:0] addr,
                         input logic [7:0] wdata, input logic [7:0] expData, input logic expErr);
    applyStimulus(rw, addr, wdata);
    @(posedge PCLK);
    #1 transfer = 1'b0;
    repeat (LAT - 1) begin
      @(posedge PCLK);
      #1;
    end
    checkOutput({name, "_hold_data"}, apb_read_data_out, prevData);
    checkOutput({name, "_hold_err"}, {7'd0, PSLVERR}, {7'd0, prevErr});
    @(posedge PCLK);
    #1;
    checkOutput({name, "_data"}, apb_read_data_out, expData);
    checkOutput({name, "_err"}, {7'd0, PSLVERR}, {7'd0, expErr});
    prevData = expData;
    prevErr  = expErr;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 9'h005, 8'h00, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 9'h012, 8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 9'h012, 8'h00, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 9'h012, 8'h11, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 9'h112, 8'h22, 8'hA5, 1'b0};
    vecs[5]  = '{1'b0, 9'h012, 8'h00, 8'h11, 1'b0};
    vecs[6]  = '{1'b0, 9'h112, 8'h00, 8'h22, 1'b0};
    vecs[7]  = '{1'b0, 9'h1FF, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 9'h112, 8'h00, 8'h22, 1'b0};
    vecs[9]  = '{1'b0, 9'h100, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 9'h0FF, 8'h7E, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 9'h0FF, 8'h00, 8'h7E, 1'b0};
    vecs[12] = '{1'b0, 9'h1FF, 8'h00, 8'h00, 1'b1};

    PRESETn         = 1'b1;
    transfer        = 1'b0;
    READ_WRITE      = 1'b0;
    apb_write_paddr = '0;
    apb_read_paddr  = '0;
    apb_write_data  = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b0;
    checkOutput("reset_data", apb_read_data_out, 8'h00);
    checkOutput("reset_err", {7'd0, PSLVERR}, 8'h00);
    prevData = 8'h00;
    prevErr  = 1'b0;

    for (int i = 0; i < 13; i++) begin
      runXfer($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
              vecs[i].expData, vecs[i].expErr);
    end

    // Back-to-back writes: next request is captured on the previous completion edge.
    applyStimulus(1'b1, 9'h000, 8'h10);
    @(posedge PCLK);
    for (int j = 0; j < 4; j++) begin
      #1;
      if (j < 3) applyStimulus(1'b1, 9'(j + 1), 8'(8'h11 + j));
      else       transfer = 1'b0;
      repeat (LAT - 1) @(posedge PCLK);
      @(posedge PCLK);
      #1;
      checkOutput($sformatf("b2b_wr%0d_err", j), {7'd0, PSLVERR}, 8'h00);
      checkOutput($sformatf("b2b_wr%0d_data", j), apb_read_data_out, prevData);
    end

    applyStimulus(1'b0, 9'h000, 8'h00);
    @(posedge PCLK);
    #1;
    for (int j = 0; j < 4; j++) begin
      if (j < 3) applyStimulus(1'b0, 9'(j + 1), 8'h00);
      else       transfer = 1'b0;
      repeat (LAT - 1) begin
        @(posedge PCLK);
        #1;
        checkOutput($sformatf("b2b_rd%0d_hold", j), apb_read_data_out, prevData);
      end
      @(posedge PCLK);
      #1;
      checkOutput($sformatf("b2b_rd%0d_data", j), apb_read_data_out, 8'(8'h10 + j));
      checkOutput($sformatf("b2b_rd%0d_err", j), {7'd0, PSLVERR}, 8'h00);
      prevData = 8'(8'h10 + j);
      prevErr  = 1'b0;
    end

    // Reset in the middle of a write: outputs clear and the write never lands.
    applyStimulus(1'b1, 9'h005, 8'h55);
    @(posedge PCLK);
    #1 transfer = 1'b0;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    #1;
    checkOutput("midrst_data", apb_read_data_out, 8'h00);
    checkOutput("midrst_err", {7'd0, PSLVERR}, 8'h00);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b0;
    prevData = 8'h00;
    prevErr  = 1'b0;
    runXfer("postrst_rd005", 1'b0, 9'h005, 8'h00, 8'h00, 1'b1);
    runXfer("postrst_rd012", 1'b0, 9'h012, 8'h00, 8'h00, 1'b1);
    runXfer("postrst_wr005", 1'b1, 9'h005, 8'h66, 8'h00, 1'b0);
    runXfer("postrst_rd005b", 1'b0, 9'h005, 8'h00, 8'h66, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
